// File: rtl/banked_memory.sv
// Banked RAM with separate write/read ports, one-cycle registered read and a zeroing sweep after reset.
// Define BANKED_MEMORY_BYPASS_EN for write-first forwarding on same-address read/write; default is read-first.
module banked_memory #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 10,
  parameter int BANK_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ready,
  output logic              drop
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int INDEX_W   = ADDR_W - BANK_BITS;
  localparam int DEPTH     = 2 ** INDEX_W;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t               r_state;
  logic [INDEX_W-1:0]   r_sweepIdx;
  logic                 r_sweepDone;
  logic [DATA_W-1:0]    r_mem [NUM_BANKS][DEPTH];

  logic [BANK_BITS-1:0] w_wBank;
  logic [INDEX_W-1:0]   w_wIdx;
  logic [BANK_BITS-1:0] w_rBank;
  logic [INDEX_W-1:0]   w_rIdx;
  logic                 w_clearWr;
  logic                 w_portWr;
  logic [DATA_W-1:0]    w_readData;

  assign w_wBank   = waddr[ADDR_W-1 -: BANK_BITS];
  assign w_wIdx    = waddr[INDEX_W-1:0];
  assign w_rBank   = raddr[ADDR_W-1 -: BANK_BITS];
  assign w_rIdx    = raddr[INDEX_W-1:0];
  assign w_clearWr = (r_state == CLEAR) && !r_sweepDone;
  assign w_portWr  = (r_state == RUN) && wen;

`ifdef BANKED_MEMORY_BYPASS_EN
  logic w_fwd;
  assign w_fwd      = wen && (waddr == raddr);
  assign w_readData = w_fwd ? wdata : r_mem[w_rBank][w_rIdx];
`else
  assign w_readData = r_mem[w_rBank][w_rIdx];
`endif

  // The sweep zeroes one index in every bank at once; port writes only land in RUN.
  always_ff @(posedge clk) begin
    if (w_clearWr) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_mem[b][r_sweepIdx] <= '0;
      end
    end else if (w_portWr) begin
      r_mem[w_wBank][w_wIdx] <= wdata;
    end
  end

  // r_sweepDone holds CLEAR one extra cycle after the last index so ready rises on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLEAR;
      r_sweepIdx  <= '0;
      r_sweepDone <= 1'b0;
      ready       <= 1'b0;
      drop        <= 1'b0;
      rvalid      <= 1'b0;
      rdata       <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          rvalid <= 1'b0;
          drop   <= wen | ren;
          if (r_sweepDone) begin
            r_state <= RUN;
            ready   <= 1'b1;
          end else if (r_sweepIdx == '1) begin
            r_sweepDone <= 1'b1;
          end else begin
            r_sweepIdx <= r_sweepIdx + INDEX_W'(1);
          end
        end
        RUN: begin
          drop   <= 1'b0;
          rvalid <= ren;
          if (ren) begin
            rdata <= w_readData;
          end
        end
        default: begin
          r_state <= CLEAR;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/banked_memory.md
# banked_memory

Parametrised banked RAM with independent write and read ports, a registered one-cycle read, and a hardware clear sweep after reset. It generalises the fixed 4-bank, 8-bit, 10-bit-address banked memory to configurable data width, address width and bank count. It adds zero-initialisation, a readiness indication and optional write-to-read forwarding. It sits behind the formal harness as the memory under test and is also used directly as a scratch store.

## Interface
Parameters:
- DATA_W, 8, data width in bits
- ADDR_W, 10, address width in bits
- BANK_BITS, 2, bank-select bits; NUM_BANKS = 2**BANK_BITS; INDEX_W = ADDR_W - BANK_BITS (must be ≥ 1)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- wen  input  1  write enable
- waddr  input  ADDR_W  write address
- wdata  input  DATA_W  write data
- ren  input  1  read enable
- raddr  input  ADDR_W  read address
- rdata  output  DATA_W  registered read data
- rvalid  output  1  rdata valid pulse
- ready  output  1  clear sweep finished; accesses accepted
- drop  output  1  one-cycle pulse: an access was presented while ready=0

## Operation
- Address split:
  - bank = addr[ADDR_W-1 -: BANK_BITS]
  - index = addr[INDEX_W-1:0]
  - Each bank is DATA_W × 2**INDEX_W.
- FSM states: CLEAR, RUN.
- Reset drives the FSM to CLEAR with sweep index 0. This applies at any time, including mid-sweep or mid-access.
- CLEAR:
  - Each cycle writes 0 to the current sweep index in every bank in parallel, then increments the index.
  - At index 2**INDEX_W-1 the index does not wrap; the FSM moves to RUN on the next edge.
  - wen and ren are ignored. Memory is untouched by the port, rvalid stays 0, and the cycle's drop is set if wen|ren.
- RUN:
  - wen=1 writes wdata to bank/index on the rising edge.
  - ren=1 captures the read; rdata/rvalid update on the next edge.
  - When ren=0, rdata holds its last value and rvalid=0.
- Simultaneous read and write:
  - Different address: both complete, with no ordering interaction.
  - Same address: see Configuration.
- Out-of-range behaviour does not exist; every ADDR_W value maps to a cell.

## Timing
- Reset values: rdata=0, rvalid=0, ready=0, drop=0, FSM=CLEAR, sweep index=0.
- Clear duration is exactly 2**INDEX_W cycles after the first rising edge with rst_n=1. With defaults, ready rises at the 257th edge (256 clear cycles, then the RUN transition registers ready).
- ready is registered and is 1 exactly while the FSM is in RUN.
- Read latency is 1 cycle: ren at edge N produces rdata/rvalid after edge N.
- Write-then-read: a write at edge N is visible to a read issued at edge N+1 or later, regardless of configuration.
- Back-to-back reads on consecutive cycles produce consecutive rvalid pulses with no bubble.
- drop is registered, so it asserts for the cycle after the offending request.

## Configuration
- BANKED_MEMORY_BYPASS_EN defined:
  - Applies when a read and a write hit the same address on the same edge in RUN.
  - rdata returns the new wdata (write-first forwarding).
- Not defined:
  - Same case returns the old cell contents (read-first).
  - No forwarding mux is synthesised.
- All other behaviour is identical in both builds.

## Test plan
- Reset release with defaults, then ren on 10'h000 and 10'h3FF right after ready: ready=0 for 256 cycles, then 1. Both reads return 8'h00 with rvalid one cycle later.
- During CLEAR, pulse wen=1, waddr=10'h2BD, wdata=8'h23: drop=1 next cycle. A post-ready read of 10'h2BD returns 8'h00.
- In RUN, write 8'h23 to 10'h2BD, then ren 10'h2BD next cycle: rdata=8'h23, rvalid=1. A read of 10'h0BD (same index, other bank) returns 8'h00.
- Same-edge write 8'hBF and read at 10'h2BD, where the cell holds 8'h23:
  - With BANKED_MEMORY_BYPASS_EN, rdata=8'hBF.
  - Without it, rdata=8'h23.
  - A following read returns 8'hBF in both builds.
- Assert rst_n=0 asynchronously mid-sweep, and again in RUN after writes: rdata, rvalid, ready and drop go to 0 immediately. A full 256-cycle sweep reruns, and earlier data reads back as 8'h00.
- Parameter sweep DATA_W=16, ADDR_W=6, BANK_BITS=3: ready after 8 clear cycles. Writing 16'hA5A5 to each of the 8 banks at index 5 reads back correctly with 1-cycle latency.
